// File: rtl/code_nco_ctrl_if.sv
// code_nco_ctrl_if: processor-side register strobes and status pulses for the code NCO controller
interface code_nco_ctrl_if #(parameter int FW = 28, parameter int SW = 11);
  logic          freq_wr;
  logic [FW-1:0] freq_in;
  logic          slew_wr;
  logic [SW-1:0] slew_in;
  logic          freq_ack;
  logic          slew_busy;
  logic          slew_done;
  logic          slew_rej;
  modport master(output freq_wr, freq_in, slew_wr, slew_in,
                 input freq_ack, slew_busy, slew_done, slew_rej);
  modport slave(input freq_wr, freq_in, slew_wr, slew_in,
                output freq_ack, slew_busy, slew_done, slew_rej);
endinterface

// File: rtl/code_nco_ctrl.sv
// code_nco_ctrl: double-buffered code NCO frequency commit on dump and half-chip slew gating
module code_nco_ctrl #(
  parameter int          FW        = 28,
  parameter int          SW        = 11,
  parameter logic [FW-1:0] FCTRL_RST = 28'h1A30552
) (
  input  logic          clk,
  input  logic          rstn,
  code_nco_ctrl_if.slave bus,
  input  logic          dump,
  input  logic          hc_enable,
  output logic [FW-1:0] f_control,
  output logic          hc_out
);
  typedef enum logic [1:0] {IDLE, ARMED, SLEW} state_t;
  state_t        state_q, state_d;
  logic [SW-1:0] count_q, count_d;
  logic [FW-1:0] pend_reg;
  logic          pend_flag, done_d, rej_d;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    rej_d   = 1'b0;
    case (state_q)
      IDLE: if (bus.slew_wr) begin
        count_d = bus.slew_in;
        state_d = ARMED;
      end
      ARMED: begin
        rej_d = bus.slew_wr;
        if (dump) begin
          state_d = (count_q == '0) ? IDLE : SLEW;
          done_d  = (count_q == '0);
        end
      end
      SLEW: begin
        rej_d = bus.slew_wr;
        if (hc_enable) begin
          count_d = count_q - 1'b1;
          state_d = (count_q == SW'(1)) ? IDLE : SLEW;
          done_d  = (count_q == SW'(1));
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      count_q       <= '0;
      bus.slew_done <= 1'b0;
      bus.slew_rej  <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      bus.slew_done <= done_d;
      bus.slew_rej  <= rej_d;
    end
  end
  // A write coincident with dump lands in the buffer after the older word has committed
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      f_control    <= FCTRL_RST;
      pend_reg     <= '0;
      pend_flag    <= 1'b0;
      bus.freq_ack <= 1'b0;
    end else begin
      if (dump && pend_flag) f_control <= pend_reg;
      if (bus.freq_wr) pend_reg <= bus.freq_in;
      pend_flag    <= bus.freq_wr | (pend_flag & ~dump);
      bus.freq_ack <= dump & pend_flag;
    end
  end
  assign bus.slew_busy = (state_q != IDLE);
  assign hc_out        = hc_enable & (state_q != SLEW);
endmodule

// File: tb/tb_code_nco_ctrl.sv
// tb_code_nco_ctrl: directed checks of frequency commit and slew gating
module tb_code_nco_ctrl;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        dump = 1'b0;
  logic        hc_enable = 1'b0;
  logic [27:0] f_control;
  logic        hc_out;
  int          n_run = 0;
  int          n_fail = 0;
  int          dropped;
  code_nco_ctrl_if bus();
  code_nco_ctrl dut(.clk(clk), .rstn(rstn), .bus(bus), .dump(dump),
                    .hc_enable(hc_enable), .f_control(f_control), .hc_out(hc_out));
  always #5 clk = ~clk;
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    bus.freq_wr = 1'b0;
    bus.freq_in = '0;
    bus.slew_wr = 1'b0;
    bus.slew_in = '0;
    tick(2);
    chk("rst_fctrl", 32'(f_control), 32'h1A30552);
    chk("rst_ack", 32'(bus.freq_ack), 0);
    chk("rst_busy", 32'(bus.slew_busy), 0);
    chk("rst_done", 32'(bus.slew_done), 0);
    chk("rst_rej", 32'(bus.slew_rej), 0);
    rstn = 1'b1;
    tick();
    bus.freq_wr = 1'b1;
    bus.freq_in = 28'h1A30600;
    tick();
    bus.freq_wr = 1'b0;
    tick(4);
    chk("pend_hold", 32'(f_control), 32'h1A30552);
    dump = 1'b1;
    tick();
    dump = 1'b0;
    chk("commit_val", 32'(f_control), 32'h1A30600);
    chk("commit_ack", 32'(bus.freq_ack), 1);
    tick();
    chk("ack_pulse", 32'(bus.freq_ack), 0);
    dump = 1'b1;
    tick();
    dump = 1'b0;
    chk("nopend_ack", 32'(bus.freq_ack), 0);
    chk("nopend_val", 32'(f_control), 32'h1A30600);
    bus.freq_wr = 1'b1;
    bus.freq_in = 28'h0AAAAAA;
    tick();
    bus.freq_in = 28'h0BBBBBB;
    tick();
    bus.freq_wr = 1'b0;
    dump = 1'b1;
    tick();
    dump = 1'b0;
    chk("overwrite_val", 32'(f_control), 32'h0BBBBBB);
    chk("overwrite_ack", 32'(bus.freq_ack), 1);
    bus.freq_wr = 1'b1;
    bus.freq_in = 28'h0DDDDDD;
    tick();
    bus.freq_in = 28'h0CCCCCC;
    dump = 1'b1;
    tick();
    bus.freq_wr = 1'b0;
    dump = 1'b0;
    chk("coinc_old", 32'(f_control), 32'h0DDDDDD);
    chk("coinc_ack", 32'(bus.freq_ack), 1);
    tick();
    chk("coinc_held", 32'(f_control), 32'h0DDDDDD);
    dump = 1'b1;
    tick();
    dump = 1'b0;
    chk("coinc_new", 32'(f_control), 32'h0CCCCCC);
    chk("coinc_ack2", 32'(bus.freq_ack), 1);
    bus.slew_wr = 1'b1;
    bus.slew_in = 11'd5;
    #1 chk("busy_pre", 32'(bus.slew_busy), 0);
    tick();
    bus.slew_wr = 1'b0;
    chk("busy_armed", 32'(bus.slew_busy), 1);
    tick(3);
    dump = 1'b1;
    hc_enable = 1'b1;
    #1 chk("hc_arm_edge", 32'(hc_out), 1);
    tick();
    dump = 1'b0;
    hc_enable = 1'b0;
    dropped = 0;
    for (int i = 1; i <= 6; i++) begin
      tick(19);
      hc_enable = 1'b1;
      #1 chk($sformatf("slew5_hc%0d", i), 32'(hc_out), (i <= 5) ? 1'b0 : 1'b1);
      if (!hc_out) dropped++;
      tick();
      hc_enable = 1'b0;
      chk($sformatf("slew5_done%0d", i), 32'(bus.slew_done), (i == 5) ? 1'b1 : 1'b0);
      chk($sformatf("slew5_busy%0d", i), 32'(bus.slew_busy), (i < 5) ? 1'b1 : 1'b0);
    end
    chk("slew5_dropped", 32'(dropped), 5);
    bus.slew_wr = 1'b1;
    bus.slew_in = 11'd4;
    tick();
    bus.slew_wr = 1'b0;
    dump = 1'b1;
    tick();
    dump = 1'b0;
    hc_enable = 1'b1;
    tick();
    hc_enable = 1'b0;
    bus.slew_wr = 1'b1;
    bus.slew_in = 11'd9;
    tick();
    bus.slew_wr = 1'b0;
    chk("rej_pulse", 32'(bus.slew_rej), 1);
    chk("rej_busy", 32'(bus.slew_busy), 1);
    tick();
    chk("rej_clear", 32'(bus.slew_rej), 0);
    for (int i = 1; i <= 4; i++) begin
      hc_enable = 1'b1;
      #1 chk($sformatf("rej_hc%0d", i), 32'(hc_out), (i <= 3) ? 1'b0 : 1'b1);
      tick();
      hc_enable = 1'b0;
      chk($sformatf("rej_done%0d", i), 32'(bus.slew_done), (i == 3) ? 1'b1 : 1'b0);
    end
    bus.slew_wr = 1'b1;
    bus.slew_in = 11'd0;
    tick();
    bus.slew_wr = 1'b0;
    chk("zero_busy", 32'(bus.slew_busy), 1);
    dump = 1'b1;
    hc_enable = 1'b1;
    #1 chk("zero_hc", 32'(hc_out), 1);
    tick();
    dump = 1'b0;
    chk("zero_done", 32'(bus.slew_done), 1);
    chk("zero_idle", 32'(bus.slew_busy), 0);
    chk("zero_hc_after", 32'(hc_out), 1);
    hc_enable = 1'b0;
    bus.slew_wr = 1'b1;
    bus.slew_in = 11'd5;
    dump = 1'b1;
    tick();
    bus.slew_wr = 1'b0;
    dump = 1'b0;
    hc_enable = 1'b1;
    #1 chk("wr_dump_armed", 32'(hc_out), 1);
    tick();
    hc_enable = 1'b0;
    dump = 1'b1;
    tick();
    dump = 1'b0;
    for (int i = 0; i < 2; i++) begin
      hc_enable = 1'b1;
      #1 chk($sformatf("pre_rst_hc%0d", i), 32'(hc_out), 0);
      tick();
      hc_enable = 1'b0;
    end
    chk("pre_rst_busy", 32'(bus.slew_busy), 1);
    hc_enable = 1'b1;
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.slew_busy), 0);
    chk("mid_rst_fctrl", 32'(f_control), 32'h1A30552);
    chk("mid_rst_hc", 32'(hc_out), 1);
    chk("mid_rst_done", 32'(bus.slew_done), 0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      hc_enable = i[0];
      #1 chk($sformatf("post_rst_hc%0d", i), 32'(hc_out), 32'(i[0]));
      tick();
      chk($sformatf("post_rst_done%0d", i), 32'(bus.slew_done), 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
